// File: rtl/fetch_decode_exec_unit_pkg.sv
// Shared widths, opcode constants and instruction field positions for the
// fetch/decode/execute slice.
package fetch_decode_exec_unit_pkg;

    localparam int unsigned INST_LEN      = 11;
    localparam int unsigned INST_SIZE_LOG = 3;
    localparam int unsigned REG_LEN       = 4;
    localparam int unsigned RF_SIZE_LOG   = 2;
    localparam int unsigned MEMI_SIZE_LOG = 3;
    localparam int unsigned MEMD_SIZE_LOG = 2;
    localparam int unsigned MEMI_WORDS    = 1 << MEMI_SIZE_LOG;

    // Instruction field bit positions: [op | rd | F | rs2]
    localparam int unsigned OP_MSB  = 10;
    localparam int unsigned OP_LSB  = 8;
    localparam int unsigned RD_MSB  = 7;
    localparam int unsigned RD_LSB  = 6;
    localparam int unsigned F_MSB   = 5;
    localparam int unsigned F_LSB   = 2;
    localparam int unsigned RS2_MSB = 1;
    localparam int unsigned RS2_LSB = 0;

    localparam logic [INST_SIZE_LOG-1:0] OP_NOP = 3'd0;
    localparam logic [INST_SIZE_LOG-1:0] OP_LI  = 3'd1;
    localparam logic [INST_SIZE_LOG-1:0] OP_ADD = 3'd2;
    localparam logic [INST_SIZE_LOG-1:0] OP_MUL = 3'd3;
    localparam logic [INST_SIZE_LOG-1:0] OP_LD  = 3'd4;
    localparam logic [INST_SIZE_LOG-1:0] OP_BR  = 3'd5;

endpackage

// File: rtl/fetch_decode_exec_unit_exec_lane.sv
// Combinational execute lane: ALU, load address, branch resolution, next PC.
// Ports: x_* operands in; x_mem_addr, x_rd_data, x_taken, x_next_pc out.
module exec_lane
    import fetch_decode_exec_unit_pkg::*;
(
    input  logic [MEMI_SIZE_LOG-1:0] x_pc,
    input  logic [INST_SIZE_LOG-1:0] x_op,
    input  logic [REG_LEN-1:0]       x_rs1_imm,
    input  logic [MEMI_SIZE_LOG-1:0] x_rs1_br_offset,
    input  logic [REG_LEN-1:0]       x_rs1_data,
    input  logic [REG_LEN-1:0]       x_rs2_data,
    input  logic                     x_rd_data_use_alu,
    input  logic                     x_is_br,
    input  logic [REG_LEN-1:0]       x_mem_data,
    output logic [MEMD_SIZE_LOG-1:0] x_mem_addr,
    output logic [REG_LEN-1:0]       x_rd_data,
    output logic                     x_taken,
    output logic [MEMI_SIZE_LOG-1:0] x_next_pc
);

    logic [REG_LEN-1:0] alu;

    // Arithmetic is done at register width, so ADD/MUL wrap mod 16.
    always_comb begin
        alu = '0;
        case (x_op)
            OP_LI:   alu = x_rs1_imm;
            OP_ADD:  alu = REG_LEN'(x_rs1_data + x_rs2_data);
            OP_MUL:  alu = REG_LEN'(x_rs1_data * x_rs2_data);
            default: alu = '0;
        endcase
    end

    assign x_mem_addr = x_rs1_data[MEMD_SIZE_LOG-1:0];
    assign x_rd_data  = x_rd_data_use_alu ? alu : x_mem_data;
    assign x_taken    = x_is_br && (x_rs2_data == '0);
    // PC arithmetic at 3 bits gives the 7 -> 0 wrap.
    assign x_next_pc  = x_taken ? MEMI_SIZE_LOG'(x_pc + x_rs1_br_offset)
                                : MEMI_SIZE_LOG'(x_pc + MEMI_SIZE_LOG'(1));

endmodule

// File: rtl/fetch_decode_exec_unit_inst_decoder.sv
// Combinational decoder from an instruction word to rename/ROB control fields.
// Ports: inst in; d_* field and flag outputs.
module inst_decoder
    import fetch_decode_exec_unit_pkg::*;
(
    input  logic [INST_LEN-1:0]      inst,
    output logic [INST_SIZE_LOG-1:0] d_opcode,
    output logic                     d_rs1_used,
    output logic [REG_LEN-1:0]       d_rs1_imm,
    output logic [MEMI_SIZE_LOG-1:0] d_rs1_br_offset,
    output logic [RF_SIZE_LOG-1:0]   d_rs1,
    output logic                     d_rs2_used,
    output logic [RF_SIZE_LOG-1:0]   d_rs2,
    output logic                     d_wen,
    output logic [RF_SIZE_LOG-1:0]   d_rd,
    output logic                     d_rd_data_use_alu,
    output logic                     d_mem_valid,
    output logic                     d_is_br
);

    // Field extraction is opcode-independent; F doubles as imm, rs1 and offset.
    assign d_opcode        = inst[OP_MSB:OP_LSB];
    assign d_rs1_imm       = inst[F_MSB:F_LSB];
    assign d_rs1           = inst[F_LSB+RF_SIZE_LOG-1:F_LSB];
    assign d_rs1_br_offset = inst[F_LSB+MEMI_SIZE_LOG-1:F_LSB];
    assign d_rs2           = inst[RS2_MSB:RS2_LSB];
    assign d_rd            = inst[RD_MSB:RD_LSB];

    // Per-opcode control flags; unlisted opcodes behave as NOP.
    always_comb begin
        d_rs1_used        = 1'b0;
        d_rs2_used        = 1'b0;
        d_wen             = 1'b0;
        d_rd_data_use_alu = 1'b0;
        d_mem_valid       = 1'b0;
        d_is_br           = 1'b0;
        case (d_opcode)
            OP_LI: begin
                d_wen             = 1'b1;
                d_rd_data_use_alu = 1'b1;
            end
            OP_ADD, OP_MUL: begin
                d_rs1_used        = 1'b1;
                d_rs2_used        = 1'b1;
                d_wen             = 1'b1;
                d_rd_data_use_alu = 1'b1;
            end
            OP_LD: begin
                d_rs1_used  = 1'b1;
                d_wen       = 1'b1;
                d_mem_valid = 1'b1;
            end
            OP_BR: begin
                d_rs2_used = 1'b1;
                d_is_br    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_decode_exec_unit_inst_mem.sv
// Instruction memory: 8x11 array, synchronous program-load port cleared by
// rst, combinational fetch port (read-before-write on a same-address write).
// Ports: clk, rst, prog_we/prog_addr/prog_data (load), f_pc -> f_inst (fetch).
module inst_mem
    import fetch_decode_exec_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [MEMI_SIZE_LOG-1:0] prog_addr,
    input  logic [INST_LEN-1:0]      prog_data,
    input  logic [MEMI_SIZE_LOG-1:0] f_pc,
    output logic [INST_LEN-1:0]      f_inst
);

    logic [INST_LEN-1:0] mem [MEMI_WORDS];

    // Reset clears every word to NOP and takes priority over programming.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MEMI_WORDS); i++) begin
                mem[i] <= '0;
            end
        end else if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign f_inst = mem[f_pc];

endmodule

// File: rtl/fetch_decode_exec_unit.sv
// Fetch/decode/execute slice wrapper: instruction memory feeding the decoder,
// plus an independent execute lane driven by the ROB.
// Ports: clk, rst, prog_* load port, f_pc/f_inst fetch, d_* decode, x_* execute.
module fetch_decode_exec_unit
    import fetch_decode_exec_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [MEMI_SIZE_LOG-1:0] prog_addr,
    input  logic [INST_LEN-1:0]      prog_data,
    input  logic [MEMI_SIZE_LOG-1:0] f_pc,
    output logic [INST_LEN-1:0]      f_inst,
    output logic [INST_SIZE_LOG-1:0] d_opcode,
    output logic                     d_rs1_used,
    output logic [REG_LEN-1:0]       d_rs1_imm,
    output logic [MEMI_SIZE_LOG-1:0] d_rs1_br_offset,
    output logic [RF_SIZE_LOG-1:0]   d_rs1,
    output logic                     d_rs2_used,
    output logic [RF_SIZE_LOG-1:0]   d_rs2,
    output logic                     d_wen,
    output logic [RF_SIZE_LOG-1:0]   d_rd,
    output logic                     d_rd_data_use_alu,
    output logic                     d_mem_valid,
    output logic                     d_is_br,
    input  logic [MEMI_SIZE_LOG-1:0] x_pc,
    input  logic [INST_SIZE_LOG-1:0] x_op,
    input  logic [REG_LEN-1:0]       x_rs1_imm,
    input  logic [MEMI_SIZE_LOG-1:0] x_rs1_br_offset,
    input  logic [REG_LEN-1:0]       x_rs1_data,
    input  logic [REG_LEN-1:0]       x_rs2_data,
    input  logic                     x_rd_data_use_alu,
    input  logic                     x_is_br,
    input  logic [REG_LEN-1:0]       x_mem_data,
    output logic [MEMD_SIZE_LOG-1:0] x_mem_addr,
    output logic [REG_LEN-1:0]       x_rd_data,
    output logic                     x_taken,
    output logic [MEMI_SIZE_LOG-1:0] x_next_pc
);

    inst_mem u_inst_mem (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .f_pc      (f_pc),
        .f_inst    (f_inst)
    );

    inst_decoder u_inst_decoder (
        .inst              (f_inst),
        .d_opcode          (d_opcode),
        .d_rs1_used        (d_rs1_used),
        .d_rs1_imm         (d_rs1_imm),
        .d_rs1_br_offset   (d_rs1_br_offset),
        .d_rs1             (d_rs1),
        .d_rs2_used        (d_rs2_used),
        .d_rs2             (d_rs2),
        .d_wen             (d_wen),
        .d_rd              (d_rd),
        .d_rd_data_use_alu (d_rd_data_use_alu),
        .d_mem_valid       (d_mem_valid),
        .d_is_br           (d_is_br)
    );

    exec_lane u_exec_lane (
        .x_pc              (x_pc),
        .x_op              (x_op),
        .x_rs1_imm         (x_rs1_imm),
        .x_rs1_br_offset   (x_rs1_br_offset),
        .x_rs1_data        (x_rs1_data),
        .x_rs2_data        (x_rs2_data),
        .x_rd_data_use_alu (x_rd_data_use_alu),
        .x_is_br           (x_is_br),
        .x_mem_data        (x_mem_data),
        .x_mem_addr        (x_mem_addr),
        .x_rd_data         (x_rd_data),
        .x_taken           (x_taken),
        .x_next_pc         (x_next_pc)
    );

endmodule

// File: tb/tb_fetch_decode_exec_unit.sv
module tb_fetch_decode_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_addr = '0;
    logic [10:0] prog_data = '0;
    logic [2:0]  f_pc = '0;
    logic [10:0] f_inst;
    logic [2:0]  d_opcode;
    logic        d_rs1_used;
    logic [3:0]  d_rs1_imm;
    logic [2:0]  d_rs1_br_offset;
    logic [1:0]  d_rs1;
    logic        d_rs2_used;
    logic [1:0]  d_rs2;
    logic        d_wen;
    logic [1:0]  d_rd;
    logic        d_rd_data_use_alu;
    logic        d_mem_valid;
    logic        d_is_br;
    logic [2:0]  x_pc = '0;
    logic [2:0]  x_op = '0;
    logic [3:0]  x_rs1_imm = '0;
    logic [2:0]  x_rs1_br_offset = '0;
    logic [3:0]  x_rs1_data = '0;
    logic [3:0]  x_rs2_data = '0;
    logic        x_rd_data_use_alu = 1'b0;
    logic        x_is_br = 1'b0;
    logic [3:0]  x_mem_data = '0;
    logic [1:0]  x_mem_addr;
    logic [3:0]  x_rd_data;
    logic        x_taken;
    logic [2:0]  x_next_pc;

    fetch_decode_exec_unit dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .f_pc(f_pc), .f_inst(f_inst),
        .d_opcode(d_opcode), .d_rs1_used(d_rs1_used), .d_rs1_imm(d_rs1_imm),
        .d_rs1_br_offset(d_rs1_br_offset), .d_rs1(d_rs1), .d_rs2_used(d_rs2_used),
        .d_rs2(d_rs2), .d_wen(d_wen), .d_rd(d_rd),
        .d_rd_data_use_alu(d_rd_data_use_alu), .d_mem_valid(d_mem_valid),
        .d_is_br(d_is_br), .x_pc(x_pc), .x_op(x_op), .x_rs1_imm(x_rs1_imm),
        .x_rs1_br_offset(x_rs1_br_offset), .x_rs1_data(x_rs1_data),
        .x_rs2_data(x_rs2_data), .x_rd_data_use_alu(x_rd_data_use_alu),
        .x_is_br(x_is_br), .x_mem_data(x_mem_data), .x_mem_addr(x_mem_addr),
        .x_rd_data(x_rd_data), .x_taken(x_taken), .x_next_pc(x_next_pc)
    );

    always #5 clk = ~clk;

    // kind: 0 = fetch word, 1 = decode bundle, 2 = execute bundle
    typedef struct {
        int          kind;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [10:0] ref_mem [8];
    bit          mem_known = 1'b0;

    // Reference decode: {op,rs1_used,imm,off,rs1,rs2_used,rs2,wen,rd,alu,mem,br}
    function automatic logic [31:0] model_decode(input logic [10:0] w);
        int op, f, rd, rs2;
        bit r1, r2, wen, alu, mem, br;
        op = int'(w) / 256;
        rd = (int'(w) / 64) % 4;
        f = (int'(w) / 4) % 16;
        rs2 = int'(w) % 4;
        r1 = 0; r2 = 0; wen = 0; alu = 0; mem = 0; br = 0;
        if (op == 1) begin wen = 1; alu = 1; end
        else if (op == 2 || op == 3) begin r1 = 1; r2 = 1; wen = 1; alu = 1; end
        else if (op == 4) begin r1 = 1; wen = 1; mem = 1; end
        else if (op == 5) begin r2 = 1; br = 1; end
        return 32'({3'(op), r1, 4'(f), 3'(f % 8), 2'(f % 4), r2, 2'(rs2),
                    wen, 2'(rd), alu, mem, br});
    endfunction

    // Reference execute: {mem_addr, rd_data, taken, next_pc}
    function automatic logic [31:0] model_exec(input int pc, op, imm, off, a, b,
                                               input bit ua, isb, input int md);
        int alu, rdv, npc;
        bit tk;
        alu = 0;
        if (op == 1) alu = imm;
        else if (op == 2) alu = (a + b) % 16;
        else if (op == 3) alu = (a * b) % 16;
        rdv = ua ? alu : md;
        tk = isb && (b == 0);
        npc = tk ? (pc + off) % 8 : (pc + 1) % 8;
        return 32'({2'(a % 4), 4'(rdv), tk, 3'(npc)});
    endfunction

    // One stimulus cycle: drive inputs, queue expectations, advance the model.
    task automatic cycle(input bit r, we, input int pa, pd, fp,
                         input int pc, op, imm, off, a, b,
                         input bit ua, isb, input int md);
        sb_entry_t e;
        rst = r; prog_we = we; prog_addr = 3'(pa); prog_data = 11'(pd); f_pc = 3'(fp);
        x_pc = 3'(pc); x_op = 3'(op); x_rs1_imm = 4'(imm); x_rs1_br_offset = 3'(off);
        x_rs1_data = 4'(a); x_rs2_data = 4'(b); x_rd_data_use_alu = ua;
        x_is_br = isb; x_mem_data = 4'(md);
        if (mem_known) begin
            e.kind = 0; e.exp = 32'(ref_mem[fp]); sb_q.push_back(e);
            e.kind = 1; e.exp = model_decode(ref_mem[fp]); sb_q.push_back(e);
        end
        e.kind = 2; e.exp = model_exec(pc, op, imm, off, a, b, ua, isb, md);
        sb_q.push_back(e);
        if (r) begin
            for (int i = 0; i < 8; i++) ref_mem[i] = '0;
            mem_known = 1'b1;
        end else if (we) begin
            ref_mem[pa] = 11'(pd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int fp);
        cycle(0, 0, 0, 0, fp, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic exec(input int pc, op, imm, off, a, b, input bit ua, isb, input int md);
        cycle(0, 0, 0, 0, 0, pc, op, imm, off, a, b, ua, isb, md);
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle against queued entries.
    always @(negedge clk) begin
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            case (e.kind)
                0: act = 32'(f_inst);
                1: act = 32'({d_opcode, d_rs1_used, d_rs1_imm, d_rs1_br_offset, d_rs1,
                              d_rs2_used, d_rs2, d_wen, d_rd, d_rd_data_use_alu,
                              d_mem_valid, d_is_br});
                default: act = 32'({x_mem_addr, x_rd_data, x_taken, x_next_pc});
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL kind%0d t=%0t actual=0x%0h required=0x%0h pc=%0d f_pc=%0d",
                         e.kind, $time, act, e.exp, x_pc, f_pc);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset, then a second reset cycle with prog_we asserted (must be ignored).
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 3, 'h7FF, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) fetch(i);
        // Same-address write and read: old word this cycle, new word next cycle.
        cycle(0, 1, 2, 'h154, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fetch(2);
        cycle(0, 1, 0, 'h2C6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 'h50C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fetch(1);
        fetch(3);
        // Execute-lane directed cases.
        exec(0, 2, 0, 0, 9, 9, 1, 0, 0);
        exec(0, 3, 0, 0, 3, 6, 1, 0, 0);
        exec(0, 1, 11, 0, 0, 0, 1, 0, 5);
        exec(0, 4, 0, 0, 14, 0, 0, 0, 7);
        exec(6, 5, 0, 3, 0, 0, 0, 1, 0);
        exec(6, 5, 0, 3, 0, 4, 0, 1, 0);
        exec(7, 5, 0, 3, 0, 4, 0, 1, 0);
        exec(7, 0, 0, 0, 0, 0, 1, 0, 9);
        exec(5, 6, 7, 0, 3, 3, 1, 0, 2);
        // Randomized traffic on all ports.
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 49) == 0), 1'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 2047)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15)),
                  1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_decode_exec_unit.md
Name: fetch_decode_exec_unit

Overview:
- Combined instruction-side and execution-side datapath slice of the simple out-of-order core.
- Holds the instruction memory (memi) with a combinational fetch port and a program-load port.
- Decodes the fetched word into rename/ROB control fields (decode).
- Provides one combinational execute lane (execute) that the ROB drives per entry to produce result, load address, branch outcome and next PC.

Parameters:
- INST_LEN, 11: instruction width.
- INST_SIZE_LOG, 3: opcode width.
- REG_LEN, 4: data register width.
- RF_SIZE_LOG, 2: register index width (4 registers).
- MEMI_SIZE_LOG, 3: instruction address width (8 words).
- MEMD_SIZE_LOG, 2: data address width (4 words).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- prog_we  in  1  instruction-memory write enable.
- prog_addr  in  3  write address.
- prog_data  in  11  write data.
- f_pc  in  3  fetch address.
- f_inst  out  11  fetched instruction.
- d_opcode  out  3  decoded opcode.
- d_rs1_used  out  1  rs1 register is read.
- d_rs1_imm  out  4  immediate value.
- d_rs1_br_offset  out  3  branch offset.
- d_rs1  out  2  rs1 register index.
- d_rs2_used  out  1  rs2 register is read.
- d_rs2  out  2  rs2 register index.
- d_wen  out  1  writes rd.
- d_rd  out  2  destination register index.
- d_rd_data_use_alu  out  1  1 = rd gets the ALU result, 0 = rd gets memory data.
- d_mem_valid  out  1  instruction is a load.
- d_is_br  out  1  instruction is a branch.
- x_pc  in  3  execute-lane PC.
- x_op  in  3  execute-lane opcode.
- x_rs1_imm  in  4  immediate.
- x_rs1_br_offset  in  3  branch offset.
- x_rs1_data  in  4  rs1 operand.
- x_rs2_data  in  4  rs2 operand.
- x_rd_data_use_alu  in  1  result select.
- x_is_br  in  1  branch flag.
- x_mem_data  in  4  data memory word at x_mem_addr, supplied externally.
- x_mem_addr  out  2  load address.
- x_rd_data  out  4  result value.
- x_taken  out  1  branch taken.
- x_next_pc  out  3  next PC.

Behaviour:
- Instruction memory is an 8x11 array.
  - On rst, every word is cleared to 0 (NOP) and prog_we is ignored.
  - Otherwise, when prog_we=1, array[prog_addr] is written at the clock edge.
  - Read is combinational: f_inst = array[f_pc].
  - A read in the same cycle as a write to that address returns the old word.
- Encoding:
  - [10:8] opcode.
  - [7:6] rd.
  - [5:2] field F.
  - [1:0] rs2.
- Opcodes: 0 NOP, 1 LI, 2 ADD, 3 MUL, 4 LD, 5 BR; 6 and 7 decode as NOP.
- Decode is purely combinational, and some fields are driven for every opcode:
  - d_opcode = inst[10:8].
  - d_rs1_imm = F.
  - d_rs1 = F[1:0].
  - d_rs1_br_offset = F[2:0].
  - d_rs2 = inst[1:0].
  - d_rd = inst[7:6].
- Decode control fields per opcode (all other flags 0):
  - LI: wen=1, use_alu=1.
  - ADD/MUL: rs1_used=1, rs2_used=1, wen=1, use_alu=1.
  - LD: rs1_used=1, wen=1, use_alu=0, mem_valid=1.
  - BR: rs2_used=1, is_br=1, wen=0.
  - NOP/illegal: all flags 0.
- Execute is purely combinational.
  - x_mem_addr = x_rs1_data[1:0], computed for every op.
  - ALU result: LI gives x_rs1_imm; ADD gives (rs1+rs2) mod 16; MUL gives the low 4 bits of rs1*rs2; all other ops give 0.
  - x_rd_data = x_rd_data_use_alu ? ALU : x_mem_data.
  - x_taken = x_is_br && (x_rs2_data == 0).
  - x_next_pc = x_taken ? (x_pc + x_rs1_br_offset) mod 8 : (x_pc + 1) mod 8. Offset is unsigned; PC wraps 7 -> 0.
- There is no internal state besides the instruction array, so decode and execute outputs are defined even during rst.

Decomposition:
- Shared package holds:
  - the width constants above;
  - opcode constants OP_NOP/LI/ADD/MUL/LD/BR;
  - instruction field bit positions.
- Three sub-modules inside the wrapper: inst_mem (array plus ports), inst_decoder, exec_lane.
- The wrapper only wires them.

Test Plan:
- rst=1 for one cycle, then read f_pc=0..7 -> f_inst=0 at every address, all d_* flags 0.
- Write 0x154 at address 2, then f_pc=2 -> f_inst=0x154; d_opcode=1, d_rd=1, d_rs1_imm=5, d_wen=1, d_use_alu=1, d_rs1_used=0.
- Decode 0x2C6 (ADD r3,r1,r2) -> d_rs1=1, d_rs2=2, rs1_used=rs2_used=1, d_rd=3. Execute with op=2, rs1=9, rs2=9 -> x_rd_data=2 (wrap). Execute with op=3, rs1=3, rs2=6 -> x_rd_data=2.
- LD: op=4, use_alu=0, rs1_data=0xE, mem_data=7 -> x_mem_addr=2, x_rd_data=7.
- BR 0x50C decodes is_br=1, offset=3, wen=0. Execute with pc=6, rs2=0 -> taken=1, next_pc=1. Execute with rs2=4 -> taken=0, next_pc=7. Execute with pc=7, not taken -> next_pc=0.
- Write and read the same address in the same cycle -> old value returned that cycle, new value the next cycle. prog_we during rst -> word stays 0.
